// File: rtl/inst_rom_pkg.sv
// inst_rom_pkg: shared fetch-bus widths, halt byte and loader state encodings.
// Holds BYTE/INSTBUS/PCLEN bus widths, INST_BYTES fetch window size,
// HALT_BYTE substituted for out-of-range reads, and the loader FSM states.
package inst_rom_pkg;
  localparam int BYTE = 8;
  localparam int INST_BYTES = 6;
  localparam int INSTBUS = BYTE * INST_BYTES;
  localparam int PCLEN = 32;
  localparam logic [BYTE-1:0] HALT_BYTE = 8'h00;
  typedef enum logic [1:0] {
    LD_IDLE,
    LD_CLEAR,
    LD_LOAD,
    LD_DONE
  } ld_state_t;
endpackage

// File: rtl/inst_rom_if.sv
// inst_rom_if: CPU fetch bus plus framed byte-stream loader bus.
// master: drives rom_addr and the ld_* request/stream signals (CPU/loader side).
// slave : returns rom_data and ld_ready/cpu_hold/ld_done (the ROM).
interface inst_rom_if
  import inst_rom_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int PC_W = PCLEN
);
  logic [PC_W-1:0] rom_addr;
  logic [INSTBUS-1:0] rom_data;
  logic ld_start;
  logic ld_clear;
  logic [ADDR_W-1:0] ld_base;
  logic [ADDR_W:0] ld_len;
  logic ld_valid;
  logic [BYTE-1:0] ld_data;
  logic ld_ready;
  logic cpu_hold;
  logic ld_done;
  modport master(
    output rom_addr, ld_start, ld_clear, ld_base, ld_len, ld_valid, ld_data,
    input rom_data, ld_ready, cpu_hold, ld_done
  );
  modport slave(
    input rom_addr, ld_start, ld_clear, ld_base, ld_len, ld_valid, ld_data,
    output rom_data, ld_ready, cpu_hold, ld_done
  );
endinterface

// File: rtl/inst_rom_array.sv
// inst_rom_array: byte array with one synchronous write port and INST_BYTES combinational read taps.
// clk  : write clock
// we/waddr/wdata : write port, lands at the rising edge
// raddr : fetch byte address (PC_W bits); rdata : window, first byte in the MSBs
// Bytes whose address is >= DEPTH read as HALT_BYTE (no aliasing). The array has no reset.
module inst_rom_array
  import inst_rom_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int PC_W = PCLEN
) (
  input  logic clk,
  input  logic we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [BYTE-1:0] wdata,
  input  logic [PC_W-1:0] raddr,
  output logic [INSTBUS-1:0] rdata
);
  localparam int DEPTH = 1 << ADDR_W;
  logic [BYTE-1:0] mem [DEPTH];
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  for (genvar i = 0; i < INST_BYTES; i++) begin : g_tap
    logic [PC_W-1:0] a;
    assign a = raddr + PC_W'(i);
    assign rdata[BYTE*(INST_BYTES-i)-1 -: BYTE] = (a < PC_W'(DEPTH)) ? mem[a[ADDR_W-1:0]] : HALT_BYTE;
  end
endmodule

// File: rtl/inst_rom.sv
// inst_rom: instruction memory with zero-latency unaligned fetch and a framed byte-stream loader.
// clk : rising-edge clock; rst : asynchronous active-high reset of the loader only
// bus : inst_rom_if slave -- fetch (rom_addr -> rom_data) and loader
//       (ld_start/ld_clear/ld_base/ld_len, ld_valid/ld_data -> ld_ready, cpu_hold, ld_done)
// Loader: IDLE -> [CLEAR: zero-fill all DEPTH bytes] -> [LOAD: len bytes at base, wrapping] -> DONE -> IDLE.
module inst_rom
  import inst_rom_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int PC_W = PCLEN
) (
  input  logic clk,
  input  logic rst,
  inst_rom_if.slave bus
);
  ld_state_t state, state_n;
  logic [ADDR_W-1:0] idx, idx_n, base, base_n, waddr;
  logic [ADDR_W:0] cnt, cnt_n, len, len_n;
  logic we;
  logic [BYTE-1:0] wdata;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LD_IDLE;
      idx <= '0;
      cnt <= '0;
      base <= '0;
      len <= '0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      cnt <= cnt_n;
      base <= base_n;
      len <= len_n;
    end
  end
  always_comb begin
    state_n = state;
    idx_n = idx;
    cnt_n = cnt;
    base_n = base;
    len_n = len;
    we = 1'b0;
    waddr = '0;
    wdata = HALT_BYTE;
    case (state)
      LD_IDLE: if (bus.ld_start) begin
        base_n = bus.ld_base;
        len_n = bus.ld_len;
        idx_n = '0;
        cnt_n = '0;
        state_n = bus.ld_clear ? LD_CLEAR : (bus.ld_len == '0) ? LD_DONE : LD_LOAD;
      end
      LD_CLEAR: begin
        we = 1'b1;
        waddr = idx;
        idx_n = idx + ADDR_W'(1);
        if (&idx) state_n = (len == '0) ? LD_DONE : LD_LOAD;
      end
      LD_LOAD: if (bus.ld_valid) begin
        we = 1'b1;
        // base+cnt truncated to ADDR_W bits gives the wrap from DEPTH-1 to 0
        waddr = base + cnt[ADDR_W-1:0];
        wdata = bus.ld_data;
        cnt_n = cnt + (ADDR_W+1)'(1);
        if (cnt_n == len) state_n = LD_DONE;
      end
      LD_DONE: state_n = LD_IDLE;
    endcase
  end
  assign bus.ld_ready = (state == LD_LOAD);
  assign bus.cpu_hold = (state != LD_IDLE);
  assign bus.ld_done = (state == LD_DONE);
  inst_rom_array #(.ADDR_W(ADDR_W), .PC_W(PC_W)) u_array (
    .clk(clk),
    .we(we),
    .waddr(waddr),
    .wdata(wdata),
    .raddr(bus.rom_addr),
    .rdata(bus.rom_data)
  );
endmodule
